uart_cmd_asm: RTL and testbench

- Sits between the UART transceiver and the command configuration block.
- Assembles incoming UART bytes into {cmd[7:0], data[15:0]} packets and presents them with a sticky cmd_rdy flag, held until the consumer acks with clr_cmd_rdy.
- Carries the consumer's one-byte response back to the UART transmitter, with single-entry buffering while the transmitter is busy.
- Recovers from partial or stalled packets with an inter-byte timeout.

---
 rtl/uart_cmd_asm.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_cmd_asm.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_asm.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_asm
// Description : Assembles UART bytes into {cmd, data} packets with an
//               inter-byte timeout, and returns one-byte responses to the
//               UART transmitter through a single-entry buffer.
//               Optional: define UART_CMD_CHKSUM_EN for 4-byte packets that
//               carry an inverted-sum checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_asm #(
    parameter logic [19:0] TMO_CYCLES = 20'd1000000,
    parameter bit          FAST_SIM   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    input  logic        tx_busy,
    output logic        trmt,
    output logic [7:0]  tx_data,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        frm_err
);

    localparam logic [19:0] c_tmo_last = FAST_SIM ? 20'd511 : (TMO_CYCLES - 20'd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GOT_CMD = 2'd1,
        ST_GOT_HI  = 2'd2,
        ST_GOT_LO  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [19:0] r_timer;
    logic [7:0]  r_shadow_cmd;
    logic [7:0]  r_shadow_hi;
    logic [7:0]  r_cmd;
    logic [15:0] r_data;
    logic        r_cmd_rdy;
    logic        r_frm_err;
    logic        r_rx_guard;
    logic        r_trmt;
    logic [7:0]  r_tx_data;
    logic        r_pend;
    logic        r_tx_guard;

    logic        w_consume;
    logic        w_ld_cmd;
    logic        w_ld_hi;
    logic        w_complete;
    logic        w_chk_err;
    logic        w_tmo;
    logic        w_launch;
    logic [7:0]  w_data_lo;

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]  r_shadow_lo;
    logic        w_ld_lo;
    logic [7:0]  w_chk_exp;

    assign w_chk_exp = ~(r_shadow_cmd + r_shadow_hi + r_shadow_lo);
    assign w_data_lo = r_shadow_lo;
`else
    assign w_data_lo = rx_data;
`endif

    // The guard cycle after each consumed byte lets rx_rdy fall before re-sampling
    assign w_consume  = rx_rdy & ~r_rx_guard & ~rst;
    assign clr_rx_rdy = w_consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_cmd    = 1'b0;
        w_ld_hi     = 1'b0;
        w_complete  = 1'b0;
        w_chk_err   = 1'b0;
        w_tmo       = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
        w_ld_lo     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_consume) begin
                    w_ld_cmd    = 1'b1;
                    w_state_nxt = ST_GOT_CMD;
                end
            end
            ST_GOT_CMD: begin
                if (w_consume) begin
                    w_ld_hi     = 1'b1;
                    w_state_nxt = ST_GOT_HI;
                end
            end
            ST_GOT_HI: begin
                if (w_consume) begin
`ifdef UART_CMD_CHKSUM_EN
                    w_ld_lo     = 1'b1;
                    w_state_nxt = ST_GOT_LO;
`else
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            ST_GOT_LO: begin
                if (w_consume) begin
                    w_state_nxt = ST_IDLE;
                    if (rx_data == w_chk_exp) begin
                        w_complete = 1'b1;
                    end else begin
                        w_chk_err  = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A byte landing on the terminal count takes priority over the timeout
        if ((r_state != ST_IDLE) && !w_consume && (r_timer == c_tmo_last)) begin
            w_tmo       = 1'b1;
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_IDLE) || w_consume || w_tmo) begin
            r_timer <= 20'd0;
        end else begin
            r_timer <= r_timer + 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_cmd <= 8'h00;
            r_shadow_hi  <= 8'h00;
`ifdef UART_CMD_CHKSUM_EN
            r_shadow_lo  <= 8'h00;
`endif
            r_cmd        <= 8'h00;
            r_data       <= 16'h0000;
            r_cmd_rdy    <= 1'b0;
            r_frm_err    <= 1'b0;
            r_rx_guard   <= 1'b0;
        end else begin
            if (w_ld_cmd) begin
                r_shadow_cmd <= rx_data;
            end
            if (w_ld_hi) begin
                r_shadow_hi <= rx_data;
            end
`ifdef UART_CMD_CHKSUM_EN
            if (w_ld_lo) begin
                r_shadow_lo <= rx_data;
            end
            if (w_tmo) begin
                r_shadow_lo <= 8'h00;
            end
`endif
            if (w_tmo) begin
                r_shadow_cmd <= 8'h00;
                r_shadow_hi  <= 8'h00;
            end
            if (w_complete) begin
                r_cmd  <= r_shadow_cmd;
                r_data <= {r_shadow_hi, w_data_lo};
            end
            if (w_complete) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
            r_frm_err  <= w_tmo | w_chk_err;
            r_rx_guard <= w_consume;
        end
    end

    // A fresh request in the launch cycle defers the launch so the newest byte is sent once
    assign w_launch = r_pend & ~tx_busy & ~r_tx_guard & ~send_resp & ~w_chk_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trmt     <= 1'b0;
            r_tx_data  <= 8'h00;
            r_pend     <= 1'b0;
            r_tx_guard <= 1'b0;
        end else begin
            r_trmt     <= w_launch;
            r_tx_guard <= w_launch;
            if (w_chk_err) begin
                r_tx_data <= 8'hEE;
                r_pend    <= 1'b1;
            end else if (send_resp) begin
                r_tx_data <= resp;
                r_pend    <= 1'b1;
            end else if (w_launch) begin
                r_pend    <= 1'b0;
            end
        end
    end

    assign trmt    = r_trmt;
    assign tx_data = r_tx_data;
    assign cmd_rdy = r_cmd_rdy;
    assign cmd     = r_cmd;
    assign data    = r_data;
    assign frm_err = r_frm_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_asm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_asm
// Description : Self-checking bench for uart_cmd_asm with directed scenarios
//               and randomized packets/responses against a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_asm;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        tx_busy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        frm_err;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          frm_total = 0;
    logic [7:0]  tx_log[$];

    uart_cmd_asm dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .tx_busy     (tx_busy),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;

    // Records what the transmitter and framing monitor would see each cycle
    always @(posedge clk) begin
        if (frm_err === 1'b1) frm_total++;
        if (trmt === 1'b1) tx_log.push_back(tx_data);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents one byte like the UART receiver; optionally acks cmd_rdy in the consuming cycle
    task automatic send_byte(input logic [7:0] b, input bit ack);
        bit ok = 1'b0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (clr_rx_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        clr_cmd_rdy = ack;
        @(negedge clk);
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL byte_consume: byte %h never consumed (clr_rx_rdy got %b, expected 1)", b, clr_rx_rdy);
        end
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo,
                            input bit ack, input int gap);
`ifdef UART_CMD_CHKSUM_EN
        logic [7:0] s;
        s = c + hi + lo;
`endif
        send_byte(c, 1'b0);
        idle(gap);
        send_byte(hi, 1'b0);
        idle(gap);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(lo, 1'b0);
        idle(gap);
        send_byte(~s, ack);
`else
        send_byte(lo, ack);
`endif
    endtask

    task automatic pulse_ack();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_cmp += 7;
        if (cmd_rdy !== 1'b0)     begin n_fail++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
        if (cmd !== 8'h00)        begin n_fail++; $display("FAIL reset_cmd: got %h expected 00", cmd); end
        if (data !== 16'h0000)    begin n_fail++; $display("FAIL reset_data: got %h expected 0000", data); end
        if (trmt !== 1'b0)        begin n_fail++; $display("FAIL reset_trmt: got %b expected 0", trmt); end
        if (tx_data !== 8'h00)    begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        if (frm_err !== 1'b0)     begin n_fail++; $display("FAIL reset_frm_err: got %b expected 0", frm_err); end
        if (clr_rx_rdy !== 1'b0)  begin n_fail++; $display("FAIL reset_clr_rx_rdy: got %b expected 0", clr_rx_rdy); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic_packet();
        n_cmp++;
        if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_pre_rdy: got %b expected 0", cmd_rdy); end
        send_pkt(8'h02, 8'h12, 8'h34, 1'b0, 0);
        n_cmp += 3;
        if (cmd_rdy !== 1'b1)   begin n_fail++; $display("FAIL basic_rdy: got %b expected 1", cmd_rdy); end
        if (cmd !== 8'h02)      begin n_fail++; $display("FAIL basic_cmd: got %h expected 02", cmd); end
        if (data !== 16'h1234)  begin n_fail++; $display("FAIL basic_data: got %h expected 1234", data); end
        pulse_ack();
        n_cmp += 3;
        if (cmd_rdy !== 1'b0)   begin n_fail++; $display("FAIL basic_ack_rdy: got %b expected 0", cmd_rdy); end
        if (cmd !== 8'h02)      begin n_fail++; $display("FAIL basic_hold_cmd: got %h expected 02", cmd); end
        if (data !== 16'h1234)  begin n_fail++; $display("FAIL basic_hold_data: got %h expected 1234", data); end
    endtask

    task automatic test_response();
        tx_busy = 1'b0;
        tx_log.delete();
        send_resp = 1'b1;
        resp      = 8'hA5;
        @(negedge clk);
        send_resp = 1'b0;
        n_cmp++;
        if (trmt !== 1'b0) begin n_fail++; $display("FAIL resp_early_trmt: got %b expected 0", trmt); end
        @(negedge clk);
        n_cmp += 2;
        if (trmt !== 1'b1)     begin n_fail++; $display("FAIL resp_trmt: got %b expected 1", trmt); end
        if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL resp_tx_data: got %h expected a5", tx_data); end
        @(negedge clk);
        n_cmp++;
        if (trmt !== 1'b0) begin n_fail++; $display("FAIL resp_trmt_pulse: got %b expected 0", trmt); end
        idle(2);
        tx_log.delete();
        tx_busy   = 1'b1;
        send_resp = 1'b1;
        resp      = 8'h11;
        @(negedge clk);
        resp      = 8'h5A;
        @(negedge clk);
        send_resp = 1'b0;
        idle(18);
        n_cmp++;
        if (tx_log.size() != 0) begin n_fail++; $display("FAIL resp_busy_hold: got %0d sends expected 0", tx_log.size()); end
        tx_busy = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (trmt !== 1'b1)     begin n_fail++; $display("FAIL resp_busy_trmt: got %b expected 1", trmt); end
        if (tx_data !== 8'h5A) begin n_fail++; $display("FAIL resp_busy_data: got %h expected 5a", tx_data); end
        idle(3);
        n_cmp++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h5A)
            begin n_fail++; $display("FAIL resp_latest_wins: got %0d sends expected exactly one 5a", tx_log.size()); end
    endtask

    task automatic test_timeout();
        int  lat = -1;
        logic rdy0;
        rdy0 = cmd_rdy;
        send_byte(8'h05, 1'b0);
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (frm_err === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if (lat != 512) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles expected 512", lat); end
        @(negedge clk);
        n_cmp += 2;
        if (frm_err !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_width: got %b expected 0", frm_err); end
        if (cmd_rdy !== rdy0) begin n_fail++; $display("FAIL tmo_cmd_rdy: got %b expected %b", cmd_rdy, rdy0); end
        send_pkt(8'h05, 8'h01, 8'hFF, 1'b0, 0);
        n_cmp += 3;
        if (cmd_rdy !== 1'b1)  begin n_fail++; $display("FAIL tmo_after_rdy: got %b expected 1", cmd_rdy); end
        if (cmd !== 8'h05)     begin n_fail++; $display("FAIL tmo_after_cmd: got %h expected 05", cmd); end
        if (data !== 16'h01FF) begin n_fail++; $display("FAIL tmo_after_data: got %h expected 01ff", data); end
        pulse_ack();
    endtask

    task automatic test_collision();
        send_pkt(8'h02, 8'h12, 8'h34, 1'b0, 1);
        n_cmp++;
        if (data !== 16'h1234) begin n_fail++; $display("FAIL coll_first_data: got %h expected 1234", data); end
        send_pkt(8'h03, 8'hAB, 8'hCD, 1'b1, 1);
        n_cmp += 3;
        if (cmd_rdy !== 1'b1)  begin n_fail++; $display("FAIL coll_rdy: got %b expected 1", cmd_rdy); end
        if (cmd !== 8'h03)     begin n_fail++; $display("FAIL coll_cmd: got %h expected 03", cmd); end
        if (data !== 16'hABCD) begin n_fail++; $display("FAIL coll_data: got %h expected abcd", data); end
        pulse_ack();
    endtask

    task automatic test_reset_mid_packet();
        int f0;
        send_pkt(8'h09, 8'h09, 8'h09, 1'b0, 0);
        tx_busy   = 1'b1;
        send_resp = 1'b1;
        resp      = 8'h99;
        @(negedge clk);
        send_resp = 1'b0;
        send_byte(8'h04, 1'b0);
        send_byte(8'h77, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp += 2;
        if (cmd_rdy !== 1'b0)  begin n_fail++; $display("FAIL rstmid_rdy: got %b expected 0", cmd_rdy); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx_data: got %h expected 00", tx_data); end
        f0 = frm_total;
        tx_busy = 1'b0;
        tx_log.delete();
        send_pkt(8'h04, 8'h00, 8'h10, 1'b0, 0);
        n_cmp += 3;
        if (cmd_rdy !== 1'b1)  begin n_fail++; $display("FAIL rstmid_after_rdy: got %b expected 1", cmd_rdy); end
        if (cmd !== 8'h04)     begin n_fail++; $display("FAIL rstmid_cmd: got %h expected 04", cmd); end
        if (data !== 16'h0010) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0010", data); end
        idle(3);
        n_cmp += 2;
        if (tx_log.size() != 0) begin n_fail++; $display("FAIL rstmid_pend: got %0d sends expected 0", tx_log.size()); end
        if (frm_total != f0)    begin n_fail++; $display("FAIL rstmid_frm_err: got %0d pulses expected 0", frm_total - f0); end
    endtask

`ifdef UART_CMD_CHKSUM_EN
    task automatic test_chksum();
        int f0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'hB7, 1'b0);
        n_cmp += 2;
        if (cmd_rdy !== 1'b1)  begin n_fail++; $display("FAIL chk_ok_rdy: got %b expected 1", cmd_rdy); end
        if (data !== 16'h1234) begin n_fail++; $display("FAIL chk_ok_data: got %h expected 1234", data); end
        pulse_ack();
        tx_log.delete();
        f0 = frm_total;
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h00, 1'b0);
        n_cmp += 2;
        if (frm_err !== 1'b1) begin n_fail++; $display("FAIL chk_bad_frm_err: got %b expected 1", frm_err); end
        if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL chk_bad_rdy: got %b expected 0", cmd_rdy); end
        idle(3);
        n_cmp += 2;
        if (tx_log.size() != 1 || tx_log[0] !== 8'hEE)
            begin n_fail++; $display("FAIL chk_bad_resp: got %0d sends expected exactly one ee", tx_log.size()); end
        if (frm_total - f0 != 1) begin n_fail++; $display("FAIL chk_bad_frm_cnt: got %0d expected 1", frm_total - f0); end
    endtask
`endif

    // Packet-level model: the last complete packet wins, partial packets cost one frm_err
    task automatic test_random_packets();
`ifdef UART_CMD_CHKSUM_EN
        int          nbytes = 4;
`else
        int          nbytes = 3;
`endif
        logic [7:0]  exp_cmd = 8'h00;
        logic [15:0] exp_data = 16'h0000;
        logic        exp_rdy = 1'b0;
        int          exp_frm = 0;
        int          f0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        f0 = frm_total;
        for (int it = 0; it < 14; it++) begin
            int gap = $urandom_range(0, 20);
            if ($urandom_range(0, 3) == 0) begin
                int nb = $urandom_range(1, nbytes - 1);
                for (int k = 0; k < nb; k++) begin
                    send_byte(8'($urandom), 1'b0);
                    idle(gap);
                end
                idle(530);
                exp_frm++;
            end else begin
                logic [7:0] c  = 8'($urandom);
                logic [7:0] hi = 8'($urandom);
                logic [7:0] lo = 8'($urandom);
                bit ack = bit'($urandom_range(0, 1));
                send_pkt(c, hi, lo, ack, gap);
                exp_cmd  = c;
                exp_data = {hi, lo};
                exp_rdy  = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    pulse_ack();
                    exp_rdy = 1'b0;
                end
            end
            idle(2);
            n_cmp += 4;
            if (cmd_rdy !== exp_rdy)        begin n_fail++; $display("FAIL rnd_rdy[%0d]: got %b expected %b", it, cmd_rdy, exp_rdy); end
            if (cmd !== exp_cmd)            begin n_fail++; $display("FAIL rnd_cmd[%0d]: got %h expected %h", it, cmd, exp_cmd); end
            if (data !== exp_data)          begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", it, data, exp_data); end
            if (frm_total - f0 != exp_frm)  begin n_fail++; $display("FAIL rnd_frm[%0d]: got %0d expected %0d", it, frm_total - f0, exp_frm); end
        end
    endtask

    task automatic test_random_resp();
        for (int it = 0; it < 10; it++) begin
            logic [7:0] r1   = 8'($urandom);
            logic [7:0] r2   = 8'($urandom);
            bit         dbl  = bit'($urandom_range(0, 1));
            int         hold = $urandom_range(0, 8);
            logic [7:0] exp_b;
            tx_log.delete();
            tx_busy   = bit'($urandom_range(0, 1));
            send_resp = 1'b1;
            resp      = r1;
            @(negedge clk);
            if (dbl) begin
                resp = r2;
                @(negedge clk);
            end
            send_resp = 1'b0;
            exp_b = dbl ? r2 : r1;
            idle(hold);
            tx_busy = 1'b0;
            idle(5);
            n_cmp += 2;
            if (tx_log.size() != 1) begin
                n_fail++;
                $display("FAIL rnd_resp_count[%0d]: got %0d sends expected 1", it, tx_log.size());
            end
            if (tx_log.size() == 0 || tx_log[tx_log.size() - 1] !== exp_b) begin
                n_fail++;
                $display("FAIL rnd_resp_byte[%0d]: got %h expected %h", it,
                         (tx_log.size() == 0) ? 8'hxx : tx_log[tx_log.size() - 1], exp_b);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        tx_busy     = 1'b0;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        resp        = 8'h00;
        test_reset();
        test_basic_packet();
        test_response();
        test_timeout();
        test_collision();
        test_reset_mid_packet();
`ifdef UART_CMD_CHKSUM_EN
        test_chksum();
`endif
        test_random_packets();
        test_random_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
